seven_seg_scanner: RTL and testbench

Time-multiplexed 4-digit seven-segment driver that consumes packed BCD produced by the ALU's binary-to-BCD converters and drives the board's common-anode display. It latches a 16-bit BCD word on a load strobe and scans one digit per refresh slot. It applies optional leading-zero blanking, per-digit decimal points and an invalid-digit indicator. All outputs are registered and active-low.

---
 rtl/seven_seg_scanner.sv | 111 +++++++++++
 tb/tb_seven_seg_scanner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment driver for a common-anode display.
// Latches packed BCD on load and scans one digit per REFRESH_DIV-cycle slot.
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [3:0]    dp_reg;

  logic          tick;
  logic [3:0]    nib;
  logic          dp_sel;
  logic [3:0]    zero;
  logic [3:0]    lead;
  logic          blank;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign tick = (cnt == CNT_MAX);

  // lead[k]: digit k and every digit above it are zero; digit 0 is never blanked
  always_comb begin
    zero[0] = (disp[3:0]   == 4'd0);
    zero[1] = (disp[7:4]   == 4'd0);
    zero[2] = (disp[11:8]  == 4'd0);
    zero[3] = (disp[15:12] == 4'd0);
    lead[3] = zero[3];
    lead[2] = zero[3] & zero[2];
    lead[1] = zero[3] & zero[2] & zero[1];
    lead[0] = 1'b0;
  end

  always_comb begin
    nib    = disp[{idx, 2'b00} +: 4];
    dp_sel = dp_reg[idx];
    blank  = blank_lz & lead[idx];

    case (nib)
      4'd0:    seg_next = 7'b1000000;
      4'd1:    seg_next = 7'b1111001;
      4'd2:    seg_next = 7'b0100100;
      4'd3:    seg_next = 7'b0110000;
      4'd4:    seg_next = 7'b0011001;
      4'd5:    seg_next = 7'b0010010;
      4'd6:    seg_next = 7'b0000010;
      4'd7:    seg_next = 7'b1111000;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0010000;
      default: seg_next = 7'b0111111;
    endcase

    an_next = ~(4'b0001 << idx);
    dp_next = ~dp_sel;

    if (!en || blank) begin
      an_next  = '1;
      seg_next = '1;
      dp_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      disp       <= '0;
      dp_reg     <= '0;
      an         <= '1;
      seg        <= '1;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        disp   <= bcd_in;
        dp_reg <= dp_in;
      end

      if (tick) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      frame_done <= tick && (idx == 2'd3);

      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4: reset, scan order,
// blanking, invalid digits, decimal points, load-on-tick and enable gating.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        en = 1'b1;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int tests_run = 0;
  int tests_failed = 0;
  int edge_no = 0;
  int off_lo = 0;
  int off_hi = -1;

  logic [3:0] exp_an  [4];
  logic [6:0] exp_seg [4];
  logic       exp_dp  [4];

  seven_seg_scanner #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .en         (en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s edge=%0d got=%h expected=%h", tag, edge_no, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic set_exp(input int d, input logic [3:0] a, input logic [6:0] s, input logic p);
    exp_an[d]  = a;
    exp_seg[d] = s;
    exp_dp[d]  = p;
  endtask

  // Asserts reset between edges, checks the asynchronous clear, then releases
  // with load held so that edge 1 captures bcd/dp; edge 1 still shows disp=0.
  task automatic do_reset(input logic [15:0] b, input logic [3:0] d, input logic blz);
    rst_n = 1'b0;
    #1;
    check("rst_an",  16'(an),         16'hF);
    check("rst_seg", 16'(seg),        16'h7F);
    check("rst_dp",  16'(dp),         16'h1);
    check("rst_fd",  16'(frame_done), 16'h0);
    bcd_in   = b;
    dp_in    = d;
    blank_lz = blz;
    load     = 1'b1;
    en       = 1'b1;
    step();
    step();
    rst_n   = 1'b1;
    edge_no = 0;
    step();
    load = 1'b0;
    check("first_an",  16'(an),  16'hE);
    check("first_seg", 16'(seg), 16'h40);
    check("first_dp",  16'(dp),  16'h1);
    check("first_fd",  16'(frame_done), 16'h0);
  endtask

  // Digit shown after edge e is ((e-1)/4)%4; frame_done follows every 16th edge.
  task automatic scan_check(input int last);
    int d;
    logic on;
    while (edge_no < last) begin
      on = !((edge_no + 1 >= off_lo) && (edge_no + 1 <= off_hi));
      en = on;
      step();
      d = ((edge_no - 1) / 4) % 4;
      if (on) begin
        check("scan_an",  16'(an),  16'(exp_an[d]));
        check("scan_seg", 16'(seg), 16'(exp_seg[d]));
        check("scan_dp",  16'(dp),  16'(exp_dp[d]));
      end else begin
        check("off_an",  16'(an),  16'hF);
        check("off_seg", 16'(seg), 16'h7F);
        check("off_dp",  16'(dp),  16'h1);
      end
      check("frame_done", 16'(frame_done), (edge_no % 16 == 0) ? 16'h1 : 16'h0);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Scan order 0x1234
    do_reset(16'h1234, 4'b0000, 1'b0);
    set_exp(0, 4'b1110, 7'b0011001, 1'b1);
    set_exp(1, 4'b1101, 7'b0110000, 1'b1);
    set_exp(2, 4'b1011, 7'b0100100, 1'b1);
    set_exp(3, 4'b0111, 7'b1111001, 1'b1);
    scan_check(42);

    // Blanking of 0x0070
    do_reset(16'h0070, 4'b0000, 1'b1);
    set_exp(0, 4'b1110, 7'b1000000, 1'b1);
    set_exp(1, 4'b1101, 7'b1111000, 1'b1);
    set_exp(2, 4'b1111, 7'b1111111, 1'b1);
    set_exp(3, 4'b1111, 7'b1111111, 1'b1);
    scan_check(17);

    // All zero with blanking: only digit 0 lit
    do_reset(16'h0000, 4'b0000, 1'b1);
    set_exp(0, 4'b1110, 7'b1000000, 1'b1);
    set_exp(1, 4'b1111, 7'b1111111, 1'b1);
    set_exp(2, 4'b1111, 7'b1111111, 1'b1);
    set_exp(3, 4'b1111, 7'b1111111, 1'b1);
    scan_check(17);

    // Invalid nibble counts as non-zero, so digit 1's zero stays lit
    do_reset(16'h0A09, 4'b0010, 1'b1);
    set_exp(0, 4'b1110, 7'b0010000, 1'b1);
    set_exp(1, 4'b1101, 7'b1000000, 1'b0);
    set_exp(2, 4'b1011, 7'b0111111, 1'b1);
    set_exp(3, 4'b1111, 7'b1111111, 1'b1);
    scan_check(17);

    // Back-to-back loads, second coincident with the idx 0->1 tick at edge 4
    do_reset(16'h0000, 4'b0000, 1'b0);
    step();
    check("lt_e2_seg", 16'(seg), 16'h40);
    bcd_in = 16'h5555;
    load   = 1'b1;
    step();
    check("lt_e3_seg", 16'(seg), 16'h40);
    bcd_in = 16'h9999;
    step();
    load = 1'b0;
    check("lt_e4_an",  16'(an),  16'hE);
    check("lt_e4_seg", 16'(seg), 16'(7'b0010010));
    set_exp(0, 4'b1110, 7'b0010000, 1'b1);
    set_exp(1, 4'b1101, 7'b0010000, 1'b1);
    set_exp(2, 4'b1011, 7'b0010000, 1'b1);
    set_exp(3, 4'b0111, 7'b0010000, 1'b1);
    scan_check(20);

    // Enable dropped for edges 7..12; scan phase and frame_done unaffected
    do_reset(16'h1234, 4'b0000, 1'b0);
    set_exp(0, 4'b1110, 7'b0011001, 1'b1);
    set_exp(1, 4'b1101, 7'b0110000, 1'b1);
    set_exp(2, 4'b1011, 7'b0100100, 1'b1);
    set_exp(3, 4'b0111, 7'b1111001, 1'b1);
    off_lo = 7;
    off_hi = 12;
    scan_check(33);
    off_lo = 0;
    off_hi = -1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout edge=%0d got=running expected=finished", edge_no);
    $fatal(1, "timeout");
  end

endmodule
